// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: datapath width, the canonical NOP and the fetch-queue entry.
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular fetch queue: entries are allocated with a PC, filled in order
// with the returned instruction, and popped from the head. clr_i empties it.
module fetch_queue
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       alloc_i,
   input  logic [XLEN-1:0]            alloc_pc_i,
   input  logic                       fill_i,
   input  logic [XLEN-1:0]            fill_instr_i,
   input  logic                       pop_i,
   output fetch_entry_t               head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [$clog2(DEPTH+1)-1:0] nfilled_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   head_q, tail_q, fptr_q;
   logic [CW-1:0]   count_q, nfill_q;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         fptr_q  <= '0;
         count_q <= '0;
         nfill_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (pop_i) begin
            mem_q[head_q].filled <= 1'b0;
            head_q <= inc(head_q);
         end
         if (fill_i) begin
            mem_q[fptr_q].instr  <= fill_instr_i;
            mem_q[fptr_q].filled <= 1'b1;
            fptr_q <= inc(fptr_q);
         end
         // When full, the popped head slot is the one reallocated; this write wins.
         if (alloc_i) begin
            mem_q[tail_q] <= '{pc: alloc_pc_i, instr: NOP_INSTR, filled: 1'b0};
            tail_q <= inc(tail_q);
         end
         count_q <= count_q + CW'(alloc_i) - CW'(pop_i);
         nfill_q <= nfill_q + CW'(fill_i) - CW'(pop_i);
      end
   end

   assign head_o    = mem_q[head_q];
   assign count_o   = count_q;
   assign nfilled_o = nfill_q;

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction-fetch stage: fetch PC, imem req/gnt/rvalid handshake, redirect
// draining. Optional FETCH_MISALIGN_EXC_EN traps misaligned redirect targets.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
   parameter int              QUEUE_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_f,
   input  logic            redirect_e,
   input  logic [XLEN-1:0] redirect_pc_e,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr_f,
   output logic [XLEN-1:0] pc_f,
   output logic [XLEN-1:0] pcplus4_f,
   output logic            valid_f
`ifdef FETCH_MISALIGN_EXC_EN
   ,output logic           misaligned_f
`endif
);

   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   // Back-to-back redirects can stack several queue-loads of stale responses.
   localparam int DW = CW + 4;

   logic [XLEN-1:0] pc_q, pc_d, tgt;
   logic [DW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   count, nfilled;
   fetch_entry_t    head;
   logic            pop, grant, fill, halt;

`ifdef FETCH_MISALIGN_EXC_EN
   logic mis_q;
   assign tgt  = redirect_pc_e;
   assign halt = mis_q;

   always_ff @(posedge clk) begin
      if (rst)             mis_q <= 1'b0;
      else if (redirect_e) mis_q <= (tgt[1:0] != 2'b00);
   end
`else
   assign tgt  = redirect_pc_e & ~32'd3;
   assign halt = 1'b0;
`endif

   assign pop       = head.filled && !stall_f && !redirect_e;
   assign imem_req  = !rst && !redirect_e && !halt && ((count < CW'(QUEUE_DEPTH)) || pop);
   assign imem_addr = pc_q;
   assign grant     = imem_req && imem_gnt;
   assign fill      = imem_rvalid && (drop_q == '0) && !redirect_e;

   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (redirect_e) begin
         pc_d   = tgt;
         // Everything granted but not yet returned is stale, except a response landing now.
         drop_d = drop_q + DW'(count) - DW'(nfilled) - DW'(imem_rvalid);
      end else begin
         if (grant) pc_d = pc_q + 32'd4;
         if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (redirect_e),
      .alloc_i      (grant),
      .alloc_pc_i   (pc_q),
      .fill_i       (fill),
      .fill_instr_i (imem_rdata),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (count),
      .nfilled_o    (nfilled)
   );

   always_comb begin
      valid_f   = head.filled;
      instr_f   = head.filled ? head.instr : NOP_INSTR;
      pc_f      = head.filled ? head.pc : '0;
      pcplus4_f = head.filled ? head.pc + 32'd4 : '0;
`ifdef FETCH_MISALIGN_EXC_EN
      misaligned_f = mis_q;
      if (mis_q) begin
         valid_f   = 1'b1;
         instr_f   = NOP_INSTR;
         pc_f      = pc_q;
         pcplus4_f = pc_q + 32'd4;
      end
`endif
   end

endmodule
